// File: rtl/bk_spi_master_if.sv
// Core-side register port and SPI pins of the bk_spi_master engine.
// The engine takes the master modport; the core / pad side takes the slave modport.
interface bk_spi_master_if;
  logic       wren_i;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic       dsr_o;
  logic       done_o;
  logic       overrun_o;
  logic       sck_o;
  logic       mosi_o;
  logic       miso_i;

  modport master (
    input  wren_i, data_i, miso_i,
    output data_o, dsr_o, done_o, overrun_o, sck_o, mosi_o
  );

  modport slave (
    output wren_i, data_i, miso_i,
    input  data_o, dsr_o, done_o, overrun_o, sck_o, mosi_o
  );
endinterface

// File: rtl/bk_spi_master.sv
// Mode-0 SPI byte engine with a one-byte holding buffer; 16*DIV ce ticks per byte.
// Writes while busy go to the buffer; a write to a full buffer is dropped and flagged.
module bk_spi_master #(
  parameter int DIV = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  bk_spi_master_if.master  io_bus
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  state_t     r_state;
  logic [7:0] r_divcnt;
  logic [2:0] r_bitcnt;
  logic [7:0] r_shreg;
  logic       r_rxbit;
  logic [7:0] r_buf;
  logic       r_buf_full;
  logic       r_sck;
  logic       r_mosi;
  logic [7:0] r_data;
  logic       r_dsr;
  logic       r_done;
  logic       r_overrun;

  logic       w_phase_edge;
  logic       w_final;
  logic       w_busy_wr;
  logic [7:0] w_shift;

  assign w_phase_edge = (r_divcnt == DIV_LAST);
  assign w_final      = (r_state == HIGH) && w_phase_edge && (r_bitcnt == 3'd7);
  assign w_shift      = {r_shreg[6:0], r_rxbit};
  // The final edge handles its own write, so only the other busy ticks use the buffer path.
  assign w_busy_wr    = io_bus.wren_i && (r_state != IDLE) && !w_final;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_divcnt   <= 8'd0;
      r_bitcnt   <= 3'd0;
      r_shreg    <= 8'd0;
      r_rxbit    <= 1'b0;
      r_buf      <= 8'd0;
      r_buf_full <= 1'b0;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_data     <= 8'd0;
      r_dsr      <= 1'b1;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (ce) begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (io_bus.wren_i) begin
            r_shreg   <= io_bus.data_i;
            r_mosi    <= io_bus.data_i[7];
            r_bitcnt  <= 3'd0;
            r_divcnt  <= 8'd0;
            r_dsr     <= 1'b0;
            r_overrun <= 1'b0;
            r_state   <= LOW;
          end
        end
        LOW: begin
          if (w_phase_edge) begin
            r_sck    <= 1'b1;
            r_rxbit  <= io_bus.miso_i;
            r_divcnt <= 8'd0;
            r_state  <= HIGH;
          end else begin
            r_divcnt <= r_divcnt + 8'd1;
          end
        end
        HIGH: begin
          if (w_phase_edge) begin
            r_sck    <= 1'b0;
            r_divcnt <= 8'd0;
            r_shreg  <= w_shift;
            r_mosi   <= r_shreg[6];
            r_bitcnt <= r_bitcnt + 3'd1;
            r_state  <= LOW;
            if (r_bitcnt == 3'd7) begin
              r_data <= w_shift;
              r_done <= 1'b1;
              if (r_buf_full) begin
                r_shreg <= r_buf;
                r_mosi  <= r_buf[7];
                if (io_bus.wren_i) begin
                  r_buf <= io_bus.data_i;
                end else begin
                  r_buf_full <= 1'b0;
                end
              end else if (io_bus.wren_i) begin
                r_shreg <= io_bus.data_i;
                r_mosi  <= io_bus.data_i[7];
              end else begin
                r_state <= IDLE;
                r_dsr   <= 1'b1;
              end
            end
          end else begin
            r_divcnt <= r_divcnt + 8'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_dsr   <= !r_buf_full;
        end
      endcase

      if (w_busy_wr) begin
        if (!r_buf_full) begin
          r_buf      <= io_bus.data_i;
          r_buf_full <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign io_bus.sck_o     = r_sck;
  assign io_bus.mosi_o    = r_mosi;
  assign io_bus.data_o    = r_data;
  assign io_bus.dsr_o     = r_dsr;
  assign io_bus.done_o    = r_done;
  assign io_bus.overrun_o = r_overrun;

endmodule

// File: tb/tb_bk_spi_master.sv
// Directed and randomized bench for bk_spi_master; a transaction-level model predicts
// per-tick sck/dsr/done/overrun/data_o and the byte stream seen on mosi.
module tb_bk_spi_master;
  localparam int D  = 4;
  localparam int NT = 4096;

  logic clk = 1'b0;
  logic reset_n;
  logic ce;

  bk_spi_master_if bus ();

  bk_spi_master #(.DIV(D)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .io_bus  (bus.master)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  int         wr_t[$];
  logic [7:0] wr_d[$];
  logic [7:0] sent_d[$];
  int         sent_s[$];
  bit         rise_m[$];

  bit         e_sck[NT];
  bit         e_dsr[NT];
  bit         e_done[NT];
  bit         e_ovr[NT];
  logic [7:0] e_dat[NT];
  int         ev[NT];
  bit         miso_bits[1024];

  int tk, tk_last, rise_n, wr_idx;
  bit prev_sck;
  int bad_sck, bad_dsr, bad_done, bad_ovr, bad_dat;
  int t0, nt, cp;
  bit lp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic add_wr(input int t, input logic [7:0] d);
    wr_t.push_back(t);
    wr_d.push_back(d);
  endtask

  function automatic logic [7:0] rx_byte(input int j, input bit loop);
    logic [7:0] b;
    b = 8'd0;
    if (loop) begin
      b = sent_d[j];
    end else begin
      for (int k = 0; k < 8; k++) b[7-k] = miso_bits[8*j+k];
    end
    return b;
  endfunction

  // Byte-level scheduling: a write either starts, waits in the single buffer, or is lost.
  task automatic model(input bit loop);
    int         cur_end;
    bit         active;
    bit         bfull;
    logic [7:0] bdat;
    int         s;
    bit         cur;
    active = 0; bfull = 0; bdat = 8'd0; cur_end = 0;
    sent_d.delete();
    sent_s.delete();
    for (int t = 0; t < NT; t++) begin
      e_sck[t] = 0; e_dsr[t] = 1; e_done[t] = 0; e_ovr[t] = 0; e_dat[t] = 8'd0; ev[t] = 0;
    end
    for (int i = 0; i < wr_t.size(); i++) begin
      while (active && cur_end < wr_t[i]) begin
        if (bfull) begin
          sent_d.push_back(bdat); sent_s.push_back(cur_end);
          cur_end += 16*D; bfull = 0;
        end else begin
          active = 0;
        end
      end
      if (!active) begin
        sent_d.push_back(wr_d[i]); sent_s.push_back(wr_t[i]);
        active = 1; cur_end = wr_t[i] + 16*D; ev[wr_t[i]] = 2;
      end else if (wr_t[i] == cur_end) begin
        if (bfull) begin
          sent_d.push_back(bdat); sent_s.push_back(cur_end); bdat = wr_d[i];
        end else begin
          sent_d.push_back(wr_d[i]); sent_s.push_back(cur_end);
        end
        cur_end += 16*D;
      end else if (!bfull) begin
        bfull = 1; bdat = wr_d[i];
      end else begin
        ev[wr_t[i]] = 1;
      end
    end
    while (active) begin
      if (bfull) begin
        sent_d.push_back(bdat); sent_s.push_back(cur_end);
        cur_end += 16*D; bfull = 0;
      end else begin
        active = 0;
      end
    end
    for (int j = 0; j < sent_d.size(); j++) begin
      s = sent_s[j];
      for (int t = s; t < s + 16*D && t < NT; t++) e_dsr[t] = 0;
      for (int k = 0; k < 8; k++)
        for (int t = s + (2*k+1)*D; t < s + (2*k+2)*D && t < NT; t++) e_sck[t] = 1;
      if (s + 16*D < NT) e_done[s + 16*D] = 1;
      for (int t = s + 16*D; t < NT; t++) e_dat[t] = rx_byte(j, loop);
    end
    cur = 0;
    for (int t = 0; t < NT; t++) begin
      if (ev[t] == 1) cur = 1;
      else if (ev[t] == 2) cur = 0;
      e_ovr[t] = cur;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    ce = 1'b0;
    bus.wren_i = 1'b0;
    bus.data_i = 8'd0;
    bus.miso_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    tk = 0; tk_last = -1; rise_n = 0; prev_sck = 0; wr_idx = 0;
    bad_sck = 0; bad_dsr = 0; bad_done = 0; bad_ovr = 0; bad_dat = 0;
    rise_m.delete(); wr_t.delete(); wr_d.delete();
    for (int i = 0; i < 1024; i++) miso_bits[i] = 1'($urandom_range(0, 1));
  endtask

  // Drives ce ticks until n_ticks have elapsed (or stop_rise sck edges seen); compares every clk.
  task automatic run(input int n_ticks, input int ce_per, input bit loop, input int stop_rise);
    int c;
    c = 0;
    while (tk < n_ticks) begin
      ce = ((c % ce_per) == 0);
      if (ce) begin
        if (wr_idx < wr_t.size() && wr_t[wr_idx] == tk) begin
          bus.wren_i = 1'b1; bus.data_i = wr_d[wr_idx]; wr_idx++;
        end else begin
          bus.wren_i = 1'b0; bus.data_i = 8'($urandom);
        end
      end else begin
        bus.wren_i = 1'($urandom_range(0, 1));
        bus.data_i = 8'($urandom);
      end
      bus.miso_i = loop ? bus.mosi_o : ((rise_n < 1024) ? miso_bits[rise_n] : 1'b0);
      @(posedge clk);
      #1;
      c++;
      if (ce) begin
        tk_last = tk;
        tk++;
        if (bus.sck_o && !prev_sck) begin
          rise_m.push_back(bus.mosi_o);
          rise_n++;
        end
        prev_sck = bus.sck_o;
      end
      if (tk_last >= 0 && tk_last < NT) begin
        if (bus.sck_o     !== e_sck[tk_last])  bad_sck++;
        if (bus.dsr_o     !== e_dsr[tk_last])  bad_dsr++;
        if (bus.done_o    !== e_done[tk_last]) bad_done++;
        if (bus.overrun_o !== e_ovr[tk_last])  bad_ovr++;
        if (bus.data_o    !== e_dat[tk_last])  bad_dat++;
      end
      if (stop_rise > 0 && rise_n == stop_rise) break;
    end
  endtask

  task automatic check_ticks(input string tag);
    chk($sformatf("%s sck_timing", tag), bad_sck, 0);
    chk($sformatf("%s dsr", tag), bad_dsr, 0);
    chk($sformatf("%s done", tag), bad_done, 0);
    chk($sformatf("%s overrun", tag), bad_ovr, 0);
    chk($sformatf("%s data_o", tag), bad_dat, 0);
  endtask

  task automatic check_bytes(input string tag);
    logic [7:0] b;
    chk($sformatf("%s rise_count", tag), rise_m.size(), 8*sent_d.size());
    for (int j = 0; j < sent_d.size(); j++) begin
      b = 8'd0;
      for (int k = 0; k < 8; k++)
        if (8*j+k < rise_m.size()) b[7-k] = rise_m[8*j+k];
      chk($sformatf("%s mosi_byte%0d", tag, j), b, sent_d[j]);
    end
    chk($sformatf("%s final_data", tag), bus.data_o, e_dat[tk_last]);
  endtask

  initial begin
    do_reset();
    chk("reset sck", bus.sck_o, 1'b0);
    chk("reset mosi", bus.mosi_o, 1'b0);
    chk("reset data_o", bus.data_o, 8'h00);
    chk("reset dsr", bus.dsr_o, 1'b1);
    chk("reset done", bus.done_o, 1'b0);
    chk("reset overrun", bus.overrun_o, 1'b0);

    add_wr(0, 8'hA5);
    model(1); run(100, 1, 1, 0);
    check_ticks("loop_a5"); check_bytes("loop_a5");
    chk("loop_a5 data", bus.data_o, 8'hA5);

    do_reset(); add_wr(2, 8'h00);
    model(0); run(90, 1, 0, 0);
    check_ticks("miso_rx"); check_bytes("miso_rx");

    do_reset(); add_wr(0, 8'h11); add_wr(5, 8'h22);
    model(1); run(150, 1, 1, 0);
    check_ticks("b2b"); check_bytes("b2b");
    chk("b2b data", bus.data_o, 8'h22);

    do_reset(); add_wr(0, 8'h11); add_wr(3, 8'h22); add_wr(6, 8'h33); add_wr(200, 8'h44);
    model(1); run(300, 1, 1, 0);
    check_ticks("overrun"); check_bytes("overrun");

    do_reset(); add_wr(0, 8'h11); add_wr(5, 8'h22); add_wr(64, 8'h33);
    model(1); run(250, 1, 1, 0);
    check_ticks("final_buf"); check_bytes("final_buf");

    do_reset(); add_wr(0, 8'h11); add_wr(64, 8'h22);
    model(1); run(150, 1, 1, 0);
    check_ticks("final_direct"); check_bytes("final_direct");

    do_reset(); add_wr(0, 8'h5A);
    model(1); run(100, 3, 1, 0);
    check_ticks("ce_div3"); check_bytes("ce_div3");
    chk("ce_div3 data", bus.data_o, 8'h5A);

    for (int r = 0; r < 4; r++) begin
      do_reset();
      cp = $urandom_range(1, 3);
      lp = 1'($urandom_range(0, 1));
      t0 = $urandom_range(0, 20);
      for (int i = 0; i < 6; i++) begin
        add_wr(t0, 8'($urandom));
        t0 += $urandom_range(1, 90);
      end
      nt = wr_t[5] + 3*16*D + 10;
      model(lp); run(nt, cp, lp, 0);
      check_ticks($sformatf("rand%0d", r)); check_bytes($sformatf("rand%0d", r));
    end

    do_reset(); add_wr(0, 8'hA5); add_wr(64, 8'hFF);
    model(1); run(200, 1, 1, 11);
    chk("rst reached_edge", rise_n, 11);
    check_ticks("rst_pre");
    chk("rst_pre data", bus.data_o, 8'hA5);
    reset_n = 1'b0;
    #1;
    chk("rst sck", bus.sck_o, 1'b0);
    chk("rst dsr", bus.dsr_o, 1'b1);
    chk("rst data_o", bus.data_o, 8'h00);
    chk("rst done", bus.done_o, 1'b0);
    chk("rst overrun", bus.overrun_o, 1'b0);
    do_reset();
    model(1); run(80, 1, 1, 0);
    check_ticks("post_rst"); check_bytes("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
